// File: rtl/int_bus_arbiter_pkg.sv
// Shared definitions for the internal bus arbiter: state encoding,
// requester index constants and a width helper.
package int_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Requester slots on the internal bus
  localparam int REQ_FETCH = 0;
  localparam int REQ_KEY   = 1;
  localparam int REQ_ACC   = 2;
  localparam int REQ_REG   = 3;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_bus_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first unmasked request starting at
// ptr (round-robin) or at index 0 (fixed priority).
module int_bus_arbiter_rr_pick
  import int_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        mask,
  input  logic [clog2(NREQ)-1:0] ptr,
  input  logic                   fixed,
  output logic [clog2(NREQ)-1:0] winner,
  output logic                   any_valid
);

  localparam int IW = clog2(NREQ);

  logic [NREQ-1:0] w_eff;

  assign w_eff = req & ~mask;

  // Scan the masked request vector from the start index, wrapping once
  always_comb begin
    int idx;
    int start;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    start     = fixed ? 0 : int'(ptr);
    for (int i = 0; i < NREQ; i++) begin
      idx = start + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_valid && w_eff[idx[IW-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/int_bus_arbiter.sv
// Internal bus arbiter: grants one tri-state driver at a time, holds the
// bus for locked transfers up to HOLD_MAX cycles and inserts one dead
// cycle whenever ownership moves to a different source.
module int_bus_arbiter
  import int_bus_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int HOLD_MAX   = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  output logic [NREQ-1:0]        grant,
  output logic [clog2(NREQ)-1:0] owner,
  output logic                   busy,
  output logic                   timeout
);

  localparam int              IW         = clog2(NREQ);
  localparam int              HW         = clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]   HOLD_LIMIT = HW'(HOLD_MAX);
  localparam logic [HW-1:0]   HOLD_ONE   = HW'(1);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

  arb_state_e      r_state, w_stateNext;
  logic [NREQ-1:0] r_grant, w_grantNext;
  logic [IW-1:0]   r_owner, w_ownerNext;
  logic [IW-1:0]   r_nextOwner, w_nextOwnerNext;
  logic [IW-1:0]   r_rrPtr, w_rrPtrNext;
  logic [HW-1:0]   r_holdCnt, w_holdCntNext;
  logic            r_timeout, w_timeoutNext;

  logic [NREQ-1:0] w_mask;
  logic [IW-1:0]   w_winner;
  logic            w_anyValid;
  logic            w_ownReq;
  logic            w_ownLock;
  logic            w_forceRelease;

  // Pointer increment with explicit wrap so non-power-of-2 NREQ works
  function automatic logic [IW-1:0] incWrap(input logic [IW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  assign w_ownReq       = req[r_owner];
  assign w_ownLock      = lock[r_owner];
  assign w_forceRelease = (r_state == OWN) && w_ownReq && w_ownLock &&
                          (r_holdCnt == HOLD_LIMIT);
  assign w_mask         = w_forceRelease ? (ONE_HOT0 << r_owner) : '0;

  int_bus_arbiter_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req      (req),
    .mask     (w_mask),
    .ptr      (r_rrPtr),
    .fixed    (FIXED_PRIO != 0),
    .winner   (w_winner),
    .any_valid(w_anyValid)
  );

  // Next-state and next-output logic for the IDLE/OWN/TURN machine
  always_comb begin
    w_stateNext     = r_state;
    w_grantNext     = r_grant;
    w_ownerNext     = r_owner;
    w_nextOwnerNext = r_nextOwner;
    w_rrPtrNext     = r_rrPtr;
    w_holdCntNext   = r_holdCnt;
    w_timeoutNext   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grantNext = '0;
        w_ownerNext = '0;
        if (w_anyValid) begin
          w_stateNext   = OWN;
          w_grantNext   = ONE_HOT0 << w_winner;
          w_ownerNext   = w_winner;
          w_holdCntNext = HOLD_ONE;
          w_rrPtrNext   = incWrap(w_winner);
        end
      end
      OWN: begin
        if (w_ownReq && w_ownLock && (r_holdCnt != HOLD_LIMIT)) begin
          w_holdCntNext = r_holdCnt + 1'b1;
        end else if (w_ownReq && !w_ownLock && w_anyValid &&
                     (w_winner == r_owner)) begin
          w_holdCntNext = HOLD_ONE;
        end else begin
          w_timeoutNext = w_forceRelease;
          w_grantNext   = '0;
          w_ownerNext   = '0;
          if (w_anyValid) begin
            w_stateNext     = TURN;
            w_nextOwnerNext = w_winner;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      TURN: begin
        w_stateNext   = OWN;
        w_grantNext   = ONE_HOT0 << r_nextOwner;
        w_ownerNext   = r_nextOwner;
        w_holdCntNext = HOLD_ONE;
        w_rrPtrNext   = incWrap(r_nextOwner);
      end
      default: begin
        w_stateNext = IDLE;
        w_grantNext = '0;
        w_ownerNext = '0;
      end
    endcase
  end

  // State and output registers; clr drops the grant immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_nextOwner <= '0;
      r_rrPtr     <= '0;
      r_holdCnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_grant     <= w_grantNext;
      r_owner     <= w_ownerNext;
      r_nextOwner <= w_nextOwnerNext;
      r_rrPtr     <= w_rrPtrNext;
      r_holdCnt   <= w_holdCntNext;
      r_timeout   <= w_timeoutNext;
    end
  end

  assign grant   = r_grant;
  assign owner   = r_owner;
  assign busy    = |r_grant;
  assign timeout = r_timeout;

endmodule
